mips_multicycle_ctrl: RTL and testbench

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

---
 rtl/mips_multicycle_ctrl.sv | 125 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath with a bounded memory wait.
// Define MIPS_CTRL_PERF_CNT_EN to build the cycle/instruction counters; otherwise both count ports read 0.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [2:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_dest,
  output logic        mem_to_reg,
  output logic [2:0]  alu_control,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
  state_t     r_state, w_next;
  logic [3:0] r_op;
  logic [2:0] r_func;
  logic [7:0] r_wait;
  logic       r_zero, r_bus_err;
  logic       w_rtype, w_imm, w_lw, w_sw, w_beq, w_bne, w_legal, w_taken;
  logic [2:0] w_alu;
  assign w_rtype = r_op == 4'd0;
  assign w_imm   = r_op inside {4'd1, 4'd2, 4'd3, 4'd4};
  assign w_lw    = r_op == 4'd5;
  assign w_sw    = r_op == 4'd6;
  assign w_beq   = r_op == 4'd7;
  assign w_bne   = r_op == 4'd8;
  assign w_legal = opcode <= 4'd8;
  // zero is registered so pc_write stays a pure function of flops
  assign w_taken = (w_beq & r_zero) | (w_bne & ~r_zero);
  assign w_alu   = w_rtype ? r_func :
                   r_op == 4'd2 ? 3'b000 :
                   r_op == 4'd3 ? 3'b001 :
                   r_op == 4'd4 ? 3'b111 :
                   (w_beq | w_bne) ? 3'b110 : 3'b010;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: if (opcode == 4'hF) w_next = S_HALT;
                else if (w_legal) w_next = S_EXEC;
                else w_next = S_FETCH;
      S_EXEC:   if (w_lw | w_sw) w_next = S_MEM;
                else if (w_beq | w_bne) w_next = S_FETCH;
                else w_next = S_WB;
      S_MEM:    if (mem_ready) w_next = w_lw ? S_WB : S_FETCH;
                else if (r_wait == WAIT_LAST) w_next = S_HALT;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_func    <= '0;
      r_wait    <= '0;
      r_zero    <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_zero  <= zero;
      if (r_state == S_DECODE) begin
        r_op   <= opcode;
        r_func <= func;
      end
      r_wait <= (r_state == S_MEM && w_next == S_MEM) ? r_wait + 8'd1 : 8'd0;
      if (r_state == S_MEM && w_next == S_HALT) r_bus_err <= 1'b1;
    end
  end
  assign pc_write    = (r_state == S_FETCH) | ((r_state == S_EXEC) & w_taken);
  assign ir_write    = r_state == S_FETCH;
  assign reg_write   = r_state == S_WB;
  assign mem_read    = (r_state == S_MEM) & w_lw;
  assign mem_write   = (r_state == S_MEM) & w_sw;
  assign alu_src     = (r_state == S_EXEC) & (w_imm | w_lw | w_sw);
  assign reg_dest    = (r_state == S_WB) & w_rtype;
  assign mem_to_reg  = (r_state == S_WB) & w_lw;
  assign alu_control = (r_state == S_EXEC) ? w_alu : 3'b000;
  assign state       = r_state;
  assign halted      = r_state == S_HALT;
  assign bus_err     = r_bus_err;
`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] r_cycles, r_instrs;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= '0;
      r_instrs <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) r_cycles <= r_cycles + 32'd1;
      if (w_next == S_FETCH && r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) r_instrs <= r_instrs + 32'd1;
    end
  end
  assign cycle_count = r_cycles;
  assign instr_count = r_instrs;
`else
  assign cycle_count = 32'd0;
  assign instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed scenarios plus randomized instruction stream checked against
// an instruction-level reference model (state trace and per-state control outputs).
module tb_mips_multicycle_ctrl;
  localparam int WMAX = 15;
`ifdef MIPS_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, start, zero, mem_ready;
  logic [3:0]  opcode;
  logic [2:0]  func;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, reg_dest, mem_to_reg;
  logic [2:0]  alu_control, state;
  logic        halted, bus_err;
  logic [31:0] cycle_count, instr_count;
  logic [10:0] obs;
  int checks = 0;
  int errors = 0;
  int exp_seq[32];
  int exp_len;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .reg_dest(reg_dest),
    .mem_to_reg(mem_to_reg), .alu_control(alu_control), .state(state), .halted(halted),
    .bus_err(bus_err), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;
  assign obs = {pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, reg_dest, mem_to_reg, alu_control};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic boot;
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expected control word for a state given the instruction being executed
  function automatic logic [10:0] model_out(input int st, input logic [3:0] op, input logic [2:0] fn, input logic z);
    logic [2:0] alu;
    alu = (op == 4'd0) ? fn : (op == 4'd2) ? 3'b000 : (op == 4'd3) ? 3'b001 :
          (op == 4'd4) ? 3'b111 : (op == 4'd7 || op == 4'd8) ? 3'b110 : 3'b010;
    case (st)
      1: return 11'b110_0000_0000;
      3: return {((op == 4'd7 && z) || (op == 4'd8 && !z)), 4'b0000, (op >= 4'd1 && op <= 4'd6), 2'b00, alu};
      4: return {3'b000, op == 4'd5, op == 4'd6, 3'b000, 3'b000};
      5: return {3'b001, 3'b000, op == 4'd0, op == 4'd5, 3'b000};
      default: return 11'd0;
    endcase
  endfunction

  // State trace from FETCH up to (not including) the next FETCH; d = MEM cycles with mem_ready low
  task automatic model_seq(input logic [3:0] op, input int d);
    exp_len = 0;
    exp_seq[exp_len++] = 1;
    exp_seq[exp_len++] = 2;
    if (op == 4'hF) begin
      exp_seq[exp_len++] = 6;
      return;
    end
    if (op > 4'd8) return;
    exp_seq[exp_len++] = 3;
    if (op <= 4'd4) exp_seq[exp_len++] = 5;
    else if (op == 4'd5 || op == 4'd6) begin
      for (int k = 0; k < ((d + 1 < WMAX) ? d + 1 : WMAX); k++) exp_seq[exp_len++] = 4;
      if (d >= WMAX) exp_seq[exp_len++] = 6;
      else if (op == 4'd5) exp_seq[exp_len++] = 5;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; mem_ready = 1'b1; zero = 1'b1; opcode = 4'h5; func = 3'b111;
    tick();
    tick();
    checks++;
    if (state !== 3'd0 || obs !== 11'd0 || halted !== 1'b0 || bus_err !== 1'b0)
      begin errors++; $display("FAIL reset_state: state=%0d out=%h halted=%b bus_err=%b, want 0/000/0/0", state, obs, halted, bus_err); end
    checks++;
    if (cycle_count !== 32'd0 || instr_count !== 32'd0)
      begin errors++; $display("FAIL reset_counts: cyc=%0d ins=%0d, want 0/0", cycle_count, instr_count); end
    reset = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: state=%0d, want 0", state); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 3'd1 || obs !== 11'b110_0000_0000)
      begin errors++; $display("FAIL idle_start: state=%0d out=%h, want 1/600", state, obs); end
  endtask

  task automatic test_rtype;
    int st[5] = '{1, 2, 3, 5, 1};
    boot();
    opcode = 4'd0; func = 3'b010; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== 3'(st[i])) begin errors++; $display("FAIL rtype_state[%0d]: state=%0d, want %0d", i, state, st[i]); end
      if (i == 2) begin
        checks++;
        if (alu_control !== 3'b010 || alu_src !== 1'b0)
          begin errors++; $display("FAIL rtype_exec: alu=%b src=%b, want 010/0", alu_control, alu_src); end
        opcode = 4'hC; func = 3'b111;
      end
      if (i == 3) begin
        checks++;
        if (reg_write !== 1'b1 || reg_dest !== 1'b1 || mem_to_reg !== 1'b0)
          begin errors++; $display("FAIL rtype_wb: rw=%b rd=%b m2r=%b, want 1/1/0", reg_write, reg_dest, mem_to_reg); end
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_lw_wait;
    int n = 1, m = 0, mrd = 0;
    boot();
    opcode = 4'd5; func = 3'($urandom); mem_ready = 1'b0;
    tick();
    while (state !== 3'd1 && n < 30) begin
      if (state == 3'd3) opcode = 4'd6;
      if (state == 3'd4) begin
        mem_ready = (m == 3);
        if (mem_read === 1'b1) mrd++;
        m++;
      end else mem_ready = 1'b0;
      if (state == 3'd5) begin
        checks++;
        if (mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dest !== 1'b0)
          begin errors++; $display("FAIL lw_wb: m2r=%b rw=%b rd=%b, want 1/1/0", mem_to_reg, reg_write, reg_dest); end
      end
      tick();
      n++;
    end
    mem_ready = 1'b0;
    checks++;
    if (n !== 8) begin errors++; $display("FAIL lw_latency: %0d cycles FETCH-to-FETCH, want 8", n); end
    checks++;
    if (m !== 4 || mrd !== 4) begin errors++; $display("FAIL lw_mem_read: mem=%0d read=%0d cycles, want 4/4", m, mrd); end
  endtask

  task automatic test_branch;
    boot();
    opcode = 4'd7; zero = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 3'd3 || pc_write !== 1'b1 || alu_control !== 3'b110)
      begin errors++; $display("FAIL beq_exec: state=%0d pc_write=%b alu=%b, want 3/1/110", state, pc_write, alu_control); end
    tick();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL beq_return: state=%0d, want 1", state); end
    opcode = 4'd8;
    tick();
    tick();
    checks++;
    if (state !== 3'd3 || pc_write !== 1'b0)
      begin errors++; $display("FAIL bne_exec: state=%0d pc_write=%b, want 3/0", state, pc_write); end
    tick();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL bne_return: state=%0d, want 1", state); end
  endtask

  task automatic test_mem_boundary;
    for (int d = WMAX - 1; d <= WMAX; d++) begin
      int m = 0, mw = 0;
      boot();
      opcode = 4'd6; mem_ready = 1'b0;
      tick();
      tick();
      tick();
      while (state == 3'd4 && m < 40) begin
        mem_ready = (m == d);
        if (mem_write === 1'b1) mw++;
        m++;
        tick();
      end
      mem_ready = 1'b0;
      checks++;
      if (m !== WMAX || mw !== WMAX)
        begin errors++; $display("FAIL sw_wait[%0d]: mem=%0d write=%0d cycles, want %0d", d, m, mw, WMAX); end
      checks++;
      if (d < WMAX && (state !== 3'd1 || bus_err !== 1'b0))
        begin errors++; $display("FAIL sw_last_ready: state=%0d bus_err=%b, want 1/0", state, bus_err); end
      else if (d == WMAX && (state !== 3'd6 || bus_err !== 1'b1 || halted !== 1'b1 || mem_write !== 1'b0))
        begin errors++; $display("FAIL sw_timeout: state=%0d bus_err=%b halted=%b mw=%b, want 6/1/1/0", state, bus_err, halted, mem_write); end
    end
  endtask

  task automatic test_halt;
    boot();
    opcode = 4'hF;
    tick();
    tick();
    start = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 3'd6 || halted !== 1'b1 || obs !== 11'd0 || bus_err !== 1'b0)
      begin errors++; $display("FAIL halt_hold: state=%0d halted=%b out=%h bus_err=%b, want 6/1/000/0", state, halted, obs, bus_err); end
    start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0 || obs !== 11'd0 || bus_err !== 1'b0)
      begin errors++; $display("FAIL halt_reset: state=%0d halted=%b out=%h, want 0/0/000", state, halted, obs); end
  endtask

  task automatic test_mem_reset;
    boot();
    opcode = 4'd5; mem_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL midwait_read: mem_read=%b, want 1", mem_read); end
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    checks++;
    if (state !== 3'd0 || obs !== 11'd0) begin errors++; $display("FAIL midwait_reset: state=%0d out=%h, want 0/000", state, obs); end
  endtask

  task automatic test_perf;
    logic [3:0] ops[3] = '{4'd0, 4'd0, 4'd7};
    boot();
    zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      opcode = ops[i]; func = 3'($urandom);
      tick();
      while (state !== 3'd1 && n < 10) begin tick(); n++; end
    end
    checks++;
    if (instr_count !== (PERF ? 32'd3 : 32'd0) || cycle_count !== (PERF ? 32'd11 : 32'd0))
      begin errors++; $display("FAIL perf_counts: ins=%0d cyc=%0d, want %0d/%0d", instr_count, cycle_count, PERF ? 3 : 0, PERF ? 11 : 0); end
  endtask

  task automatic test_random;
    int cyc_e = 0, ins_e = 0;
    boot();
    for (int n = 0; n < 120; n++) begin
      logic [3:0] op;
      logic [2:0] fn;
      logic z, stop;
      int d, r, k;
      op = 4'($urandom); fn = 3'($urandom); z = 1'($urandom);
      r = $urandom_range(0, 7);
      d = (r < 5) ? r : (r == 5) ? WMAX - 1 : WMAX;
      model_seq(op, d);
      k = 0; stop = 1'b0;
      for (int i = 0; i < exp_len && !stop; i++) begin
        int st = exp_seq[i];
        checks++;
        if (state !== 3'(st) || obs !== model_out(st, op, fn, z))
          begin errors++; $display("FAIL rand_trace n=%0d i=%0d op=%h: state=%0d out=%h, want %0d/%h", n, i, op, state, obs, st, model_out(st, op, fn, z)); end
        checks++;
        if (cycle_count !== (PERF ? 32'(cyc_e) : 32'd0) || instr_count !== (PERF ? 32'(ins_e) : 32'd0))
          begin errors++; $display("FAIL rand_counts n=%0d i=%0d: cyc=%0d ins=%0d, want %0d/%0d", n, i, cycle_count, instr_count, PERF ? cyc_e : 0, PERF ? ins_e : 0); end
        if (st == 6) begin
          checks++;
          if (halted !== 1'b1 || bus_err !== (op != 4'hF))
            begin errors++; $display("FAIL rand_halt op=%h: halted=%b bus_err=%b", op, halted, bus_err); end
          reset = 1'b1;
          tick();
          reset = 1'b0; start = 1'b1;
          tick();
          start = 1'b0; cyc_e = 0; ins_e = 0; stop = 1'b1;
        end else begin
          opcode = (i == 0 || i == 1) ? op : 4'($urandom);
          func = (i == 0 || i == 1) ? fn : 3'($urandom);
          zero = (i == 1 || i == 2) ? z : 1'($urandom);
          start = 1'($urandom);
          if (st == 4) begin mem_ready = (k == d); k++; end
          else mem_ready = 1'($urandom);
          cyc_e++;
          tick();
        end
      end
      if (!stop) ins_e++;
    end
    start = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 4'd0; func = 3'd0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_mem_boundary();
    test_halt();
    test_mem_reset();
    test_perf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
